row_mac_seq: RTL and testbench
==============================

ROW_MAC_SEQ -- requirements
Module: row_mac_seq

Interface
REQ-001 Parameters: DW = 8 (element width); ROWS = 28 (memory rows); LANES = 7 (elements per row); ACC_W = 20 (result width).
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  single-cycle request to process all ROWS rows; sampled in IDLE only.
REQ-005 mem_rd_en  out  1  read enable to the 28x7 feature memory.
REQ-006 mem_row  out  5  feature-memory row address.
REQ-007 mem_col  out  3  feature-memory column address; constant 0.
REQ-008 mem_data  in  LANES*DW  row data, combinational from the memory; lane 0 in the MSBs; each lane signed.
REQ-009 wt_data  in  LANES*DW  signed weights for the row on mem_row, same-cycle combinational, same lane order.
REQ-010 bias  in  DW  signed bias; must be stable while busy.
REQ-011 out_valid / out_ready / out_data[ACC_W-1:0] / out_row[4:0]  result handshake, signed result, row index.
REQ-012 busy  out  1  high from the cycle after start is accepted until done; done  out  1  one-cycle completion pulse.

Function
REQ-013 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN when row ROWS-1 issues; DRAIN->DONE when the pipeline is empty and no out_valid is pending; DONE->IDLE after one cycle.
REQ-014 Issue stage: in RUN, mem_rd_en = 1 and mem_row = row counter r; mem_rd_en = 0 and mem_row = 0 in every other state.
REQ-015 Advance condition adv = !out_valid || out_ready; a row issues only on an adv cycle, and r increments only on issue.
REQ-016 Stage 1 registers the LANES signed DW x DW products (2*DW bits each) and the row index at each issue; s1_valid follows the issue.
REQ-017 Stage 2 on adv: out_data = sign-extended sum of the LANES products + sign-extended bias, computed at full ACC_W precision with no saturation (range is ±7*2^14 + 2^7 < 2^19); out_row = row index carried through the pipeline; out_valid <= s1_valid.
REQ-018 Latency: out_valid rises two cycles after the issue cycle when there is no stall; throughput is one row per cycle while out_ready = 1.
REQ-019 Stall: when adv = 0, r, the stage 1 registers, out_data and out_row hold, and mem_rd_en stays high on the unissued row.
REQ-020 Transfer occurs when out_valid && out_ready; out_data and out_row are stable while out_valid is high and not yet accepted.
REQ-021 Rows are emitted exactly once, in order 0..ROWS-1; r does not wrap past ROWS-1 within a job.
REQ-022 start is ignored while the FSM is not in IDLE, including the DONE cycle.
REQ-023 done is asserted in DONE only; busy = (state == RUN || state == DRAIN).

Reset
REQ-024 reset low: state = IDLE, r = 0, s1_valid = 0, out_valid = 0, out_data = 0, out_row = 0, done = 0, busy = 0, mem_rd_en = 0, mem_row = 0, mem_col = 0.
REQ-025 Reset asserted mid-job aborts the job with no partial out_valid afterward; the next start restarts at row 0.

Configuration
REQ-026 Macro ROW_MAC_RELU_EN: when defined, the stage 2 result is clamped to 0 if negative before it is registered; when undefined, the signed result is passed unchanged. Port list is identical in both builds.

Structure
REQ-027 Shared package holds DW, ROWS, LANES, ACC_W, the FSM state enum, and the row-index width (5).
REQ-028 One sub-module, row_mac_tree: combinational LANES-input signed adder plus bias, instantiated in stage 2.

Verification
REQ-029 All mem = 1, all weights = 1, bias = 0, out_ready = 1 -> 28 results each equal to 7; out_valid is first seen 2 cycles after the first issue; done follows the last result.
REQ-030 mem = -128 and weights = -128 in all lanes, bias = 127 -> out_data = 114815 in every row, with no overflow.
REQ-031 Toggle out_ready 1/0 every cycle -> exactly 28 transfers, rows 0..27 in order, and out_data held stable during each stall.
REQ-032 mem = 1, weights = -1, bias = 0 -> out_data = -7 without ROW_MAC_RELU_EN, and out_data = 0 with it defined.
REQ-033 Assert reset at row 10 -> all outputs read 0; start after reset is released -> a full 28-row job starting at row 0.
REQ-034 start pulsed during RUN and during DONE -> ignored; exactly one job runs and done pulses once.

Source files
------------

// File: rtl/row_mac_seq_pkg.sv
// Shared constants and types for the row multiply-accumulate sequencer.
// Build option: define ROW_MAC_RELU_EN to clamp negative results to zero.
package row_mac_seq_pkg;
  localparam int DW     = 8;          // element width
  localparam int ROWS   = 28;         // feature-memory rows per job
  localparam int LANES  = 7;          // elements per row
  localparam int ACC_W  = 20;         // result width
  localparam int ROW_W  = 5;          // row-index width
  localparam int PROD_W = 2 * DW;     // full signed product width

  // FSM encoding; values are fixed so the 2-bit state register stays legacy-compatible
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Sign-extend one lane product to accumulator width
  function automatic logic [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction
endpackage

// File: rtl/row_mac_tree.sv
// Combinational LANES-input signed adder plus bias at full ACC_W precision.
// Worst case magnitude is 7*2^14 + 2^7, well inside a signed 20-bit range,
// so no saturation is needed.
module row_mac_tree
  import row_mac_seq_pkg::*;
(
  input  logic [LANES-1:0][PROD_W-1:0] prod_i,
  input  logic [DW-1:0]                bias_i,
  output logic [ACC_W-1:0]             sum_o
);

  logic [ACC_W-1:0] acc;

  // Sum sign-extended products on top of the sign-extended bias
  always_comb begin
    acc = {{(ACC_W-DW){bias_i[DW-1]}}, bias_i};
    for (int l = 0; l < LANES; l++) begin
      acc = acc + sext_prod(prod_i[l]);
    end
  end

  assign sum_o = acc;

endmodule

// File: rtl/row_mac_seq.sv
// Row MAC sequencer: walks all ROWS rows of the feature memory, multiplies
// each row by its weights, adds bias, and streams one signed result per row
// over a valid/ready handshake. Two-stage pipeline (products, then sum), the
// whole pipeline stalls together on adv = !out_valid || out_ready.
// Build option: define ROW_MAC_RELU_EN to clamp negative results to zero.
module row_mac_seq
  import row_mac_seq_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   mem_rd_en,
  output logic [ROW_W-1:0]       mem_row,
  output logic [2:0]             mem_col,
  input  logic [LANES*DW-1:0]    mem_data,
  input  logic [LANES*DW-1:0]    wt_data,
  input  logic [DW-1:0]          bias,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_data,
  output logic [ROW_W-1:0]       out_row,
  output logic                   busy,
  output logic                   done
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  logic [1:0]                   state_q, state_d;
  logic [ROW_W-1:0]             r_q, r_d;
  logic                         s1_valid_q;
  logic [LANES-1:0][PROD_W-1:0] prod_d, prod_q;
  logic [ROW_W-1:0]             s1_row_q;
  logic                         out_valid_q;
  logic [ACC_W-1:0]             out_data_q;
  logic [ROW_W-1:0]             out_row_q;
  logic [ACC_W-1:0]             sum, res;
  logic                         adv, issue;

  assign adv   = !out_valid_q || out_ready;
  assign issue = (state_q == ST_RUN) && adv;

  // Lane 0 sits in the MSBs of both buses
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [DW-1:0]     a, w;
    logic signed [PROD_W-1:0] p;
    assign a         = mem_data[(LANES-1-l)*DW +: DW];
    assign w         = wt_data[(LANES-1-l)*DW +: DW];
    assign p         = PROD_W'(a) * PROD_W'(w);
    assign prod_d[l] = p;
  end

  // Next-state logic: row counter advances only on an issued row
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          r_d     = '0;
        end
      end
      ST_RUN: begin
        if (adv) begin
          if (r_q == LAST_ROW) state_d = ST_DRAIN;
          else                 r_d     = r_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!s1_valid_q && !out_valid_q) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM and row counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
    end
  end

  // Stage 1: capture lane products and row index of the issued row
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      prod_q     <= '0;
      s1_row_q   <= '0;
    end else if (adv) begin
      s1_valid_q <= issue;
      if (issue) begin
        prod_q   <= prod_d;
        s1_row_q <= r_q;
      end
    end
  end

  row_mac_tree u_tree (
    .prod_i (prod_q),
    .bias_i (bias),
    .sum_o  (sum)
  );

`ifdef ROW_MAC_RELU_EN
  assign res = sum[ACC_W-1] ? '0 : sum;
`else
  assign res = sum;
`endif

  // Stage 2: register the result; everything holds while the consumer stalls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
    end else if (adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= res;
        out_row_q  <= s1_row_q;
      end
    end
  end

  assign mem_rd_en = (state_q == ST_RUN);
  assign mem_row   = (state_q == ST_RUN) ? r_q : '0;
  assign mem_col   = 3'd0;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_row_mac_seq.sv
// Self-checking bench for row_mac_seq: memory/weight model, transfer monitor,
// and one task per scenario compared against a plain arithmetic reference.
module tb_row_mac_seq;
  import row_mac_seq_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset, start, out_ready;
  logic                 mem_rd_en, out_valid, busy, done;
  logic [ROW_W-1:0]     mem_row, out_row;
  logic [2:0]           mem_col;
  logic [LANES*DW-1:0]  mem_data, wt_data;
  logic [DW-1:0]        bias;
  logic [ACC_W-1:0]     out_data;

  int vec = 0;
  int err = 0;

  logic signed [DW-1:0] mem [ROWS][LANES];
  logic signed [DW-1:0] wt  [ROWS][LANES];

  // monitor state
  int                cyc = 0;
  int                iss_q[$];
  int                vr_q[$];
  logic [ROW_W-1:0]  row_q[$];
  logic [ACC_W-1:0]  dat_q[$];
  int                last_x = 0, done_cyc = 0, done_cnt = 0, holds = 0, stab_err = 0;
  logic              hold_prev = 1'b0, ov_prev = 1'b0;
  logic [ACC_W-1:0]  hd = '0;
  logic [ROW_W-1:0]  hr = '0;

  always #5 clk = ~clk;

  row_mac_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_rd_en(mem_rd_en), .mem_row(mem_row), .mem_col(mem_col),
    .mem_data(mem_data), .wt_data(wt_data), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .busy(busy), .done(done)
  );

  // combinational feature memory and weight store, lane 0 in MSBs
  always_comb begin
    mem_data = '0;
    wt_data  = '0;
    if (int'(mem_row) < ROWS) begin
      for (int l = 0; l < LANES; l++) begin
        mem_data[(LANES-1-l)*DW +: DW] = mem[mem_row][l];
        wt_data[(LANES-1-l)*DW +: DW]  = wt[mem_row][l];
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // observe issues, transfers, stalls and done away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      hold_prev <= 1'b0;
      ov_prev   <= 1'b0;
    end else begin
      if (mem_rd_en && (!out_valid || out_ready)) iss_q.push_back(cyc);
      if (out_valid && !ov_prev) vr_q.push_back(cyc);
      if (out_valid && out_ready) begin
        row_q.push_back(out_row);
        dat_q.push_back(out_data);
        last_x <= cyc;
      end
      if (hold_prev) begin
        holds <= holds + 1;
        if (!out_valid || out_data !== hd || out_row !== hr) stab_err <= stab_err + 1;
      end
      hold_prev <= out_valid && !out_ready;
      hd        <= out_data;
      hr        <= out_row;
      ov_prev   <= out_valid;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
  end

  // reference: dot product of the row plus bias, optional ReLU
  function automatic int exp_row(int r);
    int s;
    s = int'($signed(bias));
    for (int l = 0; l < LANES; l++) s += int'(mem[r][l]) * int'(wt[r][l]);
`ifdef ROW_MAC_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic fill_const(input int a, input int w, input int b);
    for (int r = 0; r < ROWS; r++)
      for (int l = 0; l < LANES; l++) begin
        mem[r][l] = DW'(a);
        wt[r][l]  = DW'(w);
      end
    bias = DW'(b);
  endtask

  task automatic fill_rand();
    for (int r = 0; r < ROWS; r++)
      for (int l = 0; l < LANES; l++) begin
        mem[r][l] = DW'($urandom);
        wt[r][l]  = DW'($urandom);
      end
    bias = DW'($urandom);
  endtask

  // pulse start and wait (bounded) for the done pulse
  task automatic run_job(output bit to);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin to = 1'b0; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    vec++; if (out_data !== '0) begin err++; $display("FAIL rst_out_data got %0h want 0", out_data); end
    vec++; if (out_row !== '0) begin err++; $display("FAIL rst_out_row got %0d want 0", out_row); end
    vec++; if ({mem_rd_en, mem_row, mem_col} !== '0) begin err++; $display("FAIL rst_mem got %b/%0d/%0d want 0", mem_rd_en, mem_row, mem_col); end
    vec++; if ({busy, done} !== 2'b00) begin err++; $display("FAIL rst_busy_done got %b%b want 00", busy, done); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ones();
    int b, ib, vb, d0; bit to;
    fill_const(1, 1, 0);
    out_ready = 1'b1;
    b = row_q.size(); ib = iss_q.size(); vb = vr_q.size(); d0 = done_cnt;
    run_job(to);
    vec++; if (to) begin err++; $display("FAIL ones_timeout no done"); end
    vec++; if (row_q.size() - b != ROWS) begin err++; $display("FAIL ones_count got %0d want %0d", row_q.size() - b, ROWS); end
    for (int i = 0; i < ROWS && b + i < row_q.size(); i++) begin
      vec++;
      if (int'(row_q[b+i]) != i || int'($signed(dat_q[b+i])) != 7) begin
        err++; $display("FAIL ones_row%0d got row %0d data %0d want row %0d data 7", i, row_q[b+i], $signed(dat_q[b+i]), i);
      end
    end
    vec++;
    if (vr_q.size() <= vb || iss_q.size() <= ib || vr_q[vb] - iss_q[ib] != 2) begin
      err++; $display("FAIL ones_latency got %0d want 2", (vr_q.size() > vb && iss_q.size() > ib) ? vr_q[vb] - iss_q[ib] : -1);
    end
    vec++; if (done_cnt - d0 != 1) begin err++; $display("FAIL ones_done_cnt got %0d want 1", done_cnt - d0); end
    vec++; if (!(done_cyc > last_x)) begin err++; $display("FAIL ones_done_order done %0d last xfer %0d", done_cyc, last_x); end
  endtask

  task automatic test_extreme();
    int b; bit to;
    fill_const(-128, -128, 127);
    out_ready = 1'b1;
    b = row_q.size();
    run_job(to);
    vec++; if (to || row_q.size() - b != ROWS) begin err++; $display("FAIL ext_count got %0d want %0d", row_q.size() - b, ROWS); end
    for (int i = 0; i < ROWS && b + i < row_q.size(); i++) begin
      vec++;
      if (int'($signed(dat_q[b+i])) != 114815 || int'(row_q[b+i]) != i) begin
        err++; $display("FAIL ext_row%0d got %0d want 114815", i, $signed(dat_q[b+i]));
      end
    end
  endtask

  task automatic test_toggle_ready();
    int b, h0, s0; bit to, stop;
    fill_rand();
    b = row_q.size(); h0 = holds; s0 = stab_err; stop = 1'b0;
    fork
      begin run_job(to); stop = 1'b1; end
      begin while (!stop) begin @(posedge clk); #1 out_ready = ~out_ready; end end
    join
    out_ready = 1'b1;
    vec++; if (to || row_q.size() - b != ROWS) begin err++; $display("FAIL tog_count got %0d want %0d", row_q.size() - b, ROWS); end
    for (int i = 0; i < ROWS && b + i < row_q.size(); i++) begin
      vec++;
      if (int'(row_q[b+i]) != i || int'($signed(dat_q[b+i])) != exp_row(i)) begin
        err++; $display("FAIL tog_row%0d got row %0d data %0d want data %0d", i, row_q[b+i], $signed(dat_q[b+i]), exp_row(i));
      end
    end
    vec++; if (holds == h0) begin err++; $display("FAIL tog_no_stall got 0 stalls want >0"); end
    vec++; if (stab_err != s0) begin err++; $display("FAIL tog_stable got %0d unstable cycles want 0", stab_err - s0); end
  endtask

  task automatic test_back_to_back();
    int b, s0; bit to, stop;
    for (int job = 0; job < 3; job++) begin
      fill_rand();
      b = row_q.size(); s0 = stab_err; stop = 1'b0;
      fork
        begin run_job(to); stop = 1'b1; end
        begin while (!stop) begin @(posedge clk); #1 out_ready = ($urandom_range(0, 3) != 0); end end
      join
      out_ready = 1'b1;
      vec++; if (to || row_q.size() - b != ROWS) begin err++; $display("FAIL b2b%0d_count got %0d want %0d", job, row_q.size() - b, ROWS); end
      for (int i = 0; i < ROWS && b + i < row_q.size(); i++) begin
        vec++;
        if (int'(row_q[b+i]) != i || int'($signed(dat_q[b+i])) != exp_row(i)) begin
          err++; $display("FAIL b2b%0d_row%0d got row %0d data %0d want %0d", job, i, row_q[b+i], $signed(dat_q[b+i]), exp_row(i));
        end
      end
      vec++; if (stab_err != s0) begin err++; $display("FAIL b2b%0d_stable got %0d want 0", job, stab_err - s0); end
    end
  endtask

  task automatic test_negative();
    int b, lit; bit to;
    fill_const(1, -1, 0);
    out_ready = 1'b1;
    b = row_q.size();
`ifdef ROW_MAC_RELU_EN
    lit = 0;
`else
    lit = -7;
`endif
    run_job(to);
    vec++; if (to || row_q.size() - b != ROWS) begin err++; $display("FAIL neg_count got %0d want %0d", row_q.size() - b, ROWS); end
    for (int i = 0; i < ROWS && b + i < row_q.size(); i++) begin
      vec++;
      if (int'($signed(dat_q[b+i])) != lit) begin
        err++; $display("FAIL neg_row%0d got %0d want %0d", i, $signed(dat_q[b+i]), lit);
      end
    end
  endtask

  task automatic test_reset_mid();
    int b; bit to, hit;
    fill_rand();
    out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_rd_en && mem_row == 5'd10) begin hit = 1'b1; break; end
    end
    vec++; if (!hit) begin err++; $display("FAIL rmid_reach_row10 got none want row 10"); end
    reset = 1'b0;
    #1;
    vec++; if ({out_valid, out_data, out_row} !== '0) begin err++; $display("FAIL rmid_out got %b/%0h/%0d want 0", out_valid, out_data, out_row); end
    vec++; if ({mem_rd_en, mem_row, busy, done} !== '0) begin err++; $display("FAIL rmid_ctl got %b/%0d/%b/%b want 0", mem_rd_en, mem_row, busy, done); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    b = row_q.size();
    repeat (6) @(negedge clk);
    vec++; if (row_q.size() != b || out_valid !== 1'b0) begin err++; $display("FAIL rmid_no_partial got %0d xfers want 0", row_q.size() - b); end
    run_job(to);
    vec++; if (to || row_q.size() - b != ROWS) begin err++; $display("FAIL rmid_count got %0d want %0d", row_q.size() - b, ROWS); end
    for (int i = 0; i < ROWS && b + i < row_q.size(); i++) begin
      vec++;
      if (int'(row_q[b+i]) != i || int'($signed(dat_q[b+i])) != exp_row(i)) begin
        err++; $display("FAIL rmid_row%0d got row %0d data %0d want %0d", i, row_q[b+i], $signed(dat_q[b+i]), exp_row(i));
      end
    end
  endtask

  task automatic test_start_ignored();
    int b, d0; bit hit;
    fill_rand();
    out_ready = 1'b1;
    b = row_q.size(); d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin hit = 1'b1; break; end
    end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (40) @(negedge clk);
    vec++; if (!hit) begin err++; $display("FAIL sti_done_seen got none want 1"); end
    vec++; if (done_cnt - d0 != 1) begin err++; $display("FAIL sti_done_cnt got %0d want 1", done_cnt - d0); end
    vec++; if (row_q.size() - b != ROWS) begin err++; $display("FAIL sti_xfers got %0d want %0d", row_q.size() - b, ROWS); end
    vec++; if ({busy, mem_rd_en} !== 2'b00) begin err++; $display("FAIL sti_idle got busy %b rd %b want 0 0", busy, mem_rd_en); end
  endtask

  initial begin
    start = 1'b0;
    out_ready = 1'b1;
    fill_const(0, 0, 0);
    test_reset();
    test_ones();
    test_extreme();
    test_toggle_ready();
    test_back_to_back();
    test_negative();
    test_reset_mid();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
